// File: rtl/rs_issue_queue.sv
// Reservation station for the ALU/branch path: buffers dispatched instructions,
// snoops the CDB for operands and issues the oldest ready entry through a registered output stage.
module rs_issue_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned N_CDB    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [ADDR_W-1:0]          disp_pc,
  input  logic [DATA_W-1:0]          disp_imm,
  input  logic [ROB_ID_W-1:0]        disp_rob_id,
  input  logic [DATA_W-1:0]          disp_vj,
  input  logic [DATA_W-1:0]          disp_vk,
  input  logic [ROB_ID_W-1:0]        disp_qj,
  input  logic [ROB_ID_W-1:0]        disp_qk,
  input  logic                       disp_qj_pend,
  input  logic                       disp_qk_pend,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [N_CDB*DATA_W-1:0]    cdb_value,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [ADDR_W-1:0]          iss_pc,
  output logic [DATA_W-1:0]          iss_imm,
  output logic [DATA_W-1:0]          iss_vj,
  output logic [DATA_W-1:0]          iss_vk,
  output logic [ROB_ID_W-1:0]        iss_rob_id,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                busy_q [DEPTH];
  logic                busy_d [DEPTH];
  logic [OP_W-1:0]     op_q   [DEPTH];
  logic [OP_W-1:0]     op_d   [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_d   [DEPTH];
  logic [DATA_W-1:0]   imm_q  [DEPTH];
  logic [DATA_W-1:0]   imm_d  [DEPTH];
  logic [ROB_ID_W-1:0] rob_q  [DEPTH];
  logic [ROB_ID_W-1:0] rob_d  [DEPTH];
  logic [DATA_W-1:0]   vj_q   [DEPTH];
  logic [DATA_W-1:0]   vj_d   [DEPTH];
  logic [DATA_W-1:0]   vk_q   [DEPTH];
  logic [DATA_W-1:0]   vk_d   [DEPTH];
  logic [ROB_ID_W-1:0] qj_q   [DEPTH];
  logic [ROB_ID_W-1:0] qj_d   [DEPTH];
  logic [ROB_ID_W-1:0] qk_q   [DEPTH];
  logic [ROB_ID_W-1:0] qk_d   [DEPTH];
  logic                qjp_q  [DEPTH];
  logic                qjp_d  [DEPTH];
  logic                qkp_q  [DEPTH];
  logic                qkp_d  [DEPTH];
  logic [AW-1:0]       age_q  [DEPTH];
  logic [AW-1:0]       age_d  [DEPTH];

  logic                iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]     iss_op_q, iss_op_d;
  logic [ADDR_W-1:0]   iss_pc_q, iss_pc_d;
  logic [DATA_W-1:0]   iss_imm_q, iss_imm_d;
  logic [DATA_W-1:0]   iss_vj_q, iss_vj_d;
  logic [DATA_W-1:0]   iss_vk_q, iss_vk_d;
  logic [ROB_ID_W-1:0] iss_rob_q, iss_rob_d;
  logic [CW-1:0]       count_q, count_d;

  logic                sel_found;
  logic [AW-1:0]       sel_idx;
  logic [AW-1:0]       sel_age;
  logic [AW-1:0]       free_idx;
  logic                load;
  logic                disp_fire;
  logic [DATA_W:0]     lk_j, lk_k;

  // {hit, value} from the lowest-indexed valid CDB port carrying tag.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_ID_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int p = int'(N_CDB) - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_rob_id[p*ROB_ID_W +: ROB_ID_W] == tag)) begin
        res = {1'b1, cdb_value[p*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign disp_ready = rdy && (count_q != CW'(DEPTH));
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_valid  = iss_valid_q;
  assign iss_op     = iss_op_q;
  assign iss_pc     = iss_pc_q;
  assign iss_imm    = iss_imm_q;
  assign iss_vj     = iss_vj_q;
  assign iss_vk     = iss_vk_q;
  assign iss_rob_id = iss_rob_q;

  // Oldest-ready select on registered state, plus lowest free slot.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    free_idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (busy_q[i] && !qjp_q[i] && !qkp_q[i] && (!sel_found || (age_q[i] > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
        sel_age   = age_q[i];
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = AW'(i);
    end
  end

  assign load = sel_found && (!iss_valid_q || iss_ready);

  always_comb begin
    busy_d      = busy_q;
    op_d        = op_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rob_d       = rob_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    qjp_d       = qjp_q;
    qkp_d       = qkp_q;
    age_d       = age_q;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_pc_d    = iss_pc_q;
    iss_imm_d   = iss_imm_q;
    iss_vj_d    = iss_vj_q;
    iss_vk_d    = iss_vk_q;
    iss_rob_d   = iss_rob_q;
    count_d     = count_q;
    lk_j        = '0;
    lk_k        = '0;

    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) busy_d[i] = 1'b0;
      iss_valid_d = 1'b0;
      count_d     = '0;
    end else if (rdy) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (busy_q[i]) begin
          lk_j = cdb_lookup(qj_q[i]);
          lk_k = cdb_lookup(qk_q[i]);
          if (qjp_q[i] && lk_j[DATA_W]) begin
            vj_d[i]  = lk_j[DATA_W-1:0];
            qjp_d[i] = 1'b0;
          end
          if (qkp_q[i] && lk_k[DATA_W]) begin
            vk_d[i]  = lk_k[DATA_W-1:0];
            qkp_d[i] = 1'b0;
          end
        end
      end

      if (load) begin
        iss_valid_d     = 1'b1;
        iss_op_d        = op_q[sel_idx];
        iss_pc_d        = pc_q[sel_idx];
        iss_imm_d       = imm_q[sel_idx];
        iss_vj_d        = vj_q[sel_idx];
        iss_vk_d        = vk_q[sel_idx];
        iss_rob_d       = rob_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end else if (iss_ready) begin
        iss_valid_d = 1'b0;
      end

      // The entry leaving this cycle is excluded from aging.
      if (disp_fire) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (busy_q[i] && !(load && (sel_idx == AW'(i)))) age_d[i] = age_q[i] + AW'(1);
        end
        lk_j = cdb_lookup(disp_qj);
        lk_k = cdb_lookup(disp_qk);
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op;
        pc_d[free_idx]   = disp_pc;
        imm_d[free_idx]  = disp_imm;
        rob_d[free_idx]  = disp_rob_id;
        qj_d[free_idx]   = disp_qj;
        qk_d[free_idx]   = disp_qk;
        age_d[free_idx]  = '0;
        vj_d[free_idx]   = (disp_qj_pend && lk_j[DATA_W]) ? lk_j[DATA_W-1:0] : disp_vj;
        vk_d[free_idx]   = (disp_qk_pend && lk_k[DATA_W]) ? lk_k[DATA_W-1:0] : disp_vk;
        qjp_d[free_idx]  = disp_qj_pend && !lk_j[DATA_W];
        qkp_d[free_idx]  = disp_qk_pend && !lk_k[DATA_W];
      end

      count_d = count_q + CW'(disp_fire) - CW'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) busy_q[i] <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_pc_q    <= '0;
      iss_imm_q   <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_rob_q   <= '0;
      count_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_pc_q    <= iss_pc_d;
      iss_imm_q   <= iss_imm_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
      iss_rob_q   <= iss_rob_d;
      count_q     <= count_d;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    pc_q  <= pc_d;
    imm_q <= imm_d;
    rob_q <= rob_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    qjp_q <= qjp_d;
    qkp_q <= qkp_d;
    age_q <= age_d;
  end

endmodule
